execute_nway: RTL and testbench
===============================

Name: execute_nway

Overview:
- Parametrised N-lane successor to the dual-issue execute stage.
- Holds the ID/EX pipeline register for LANES issue slots and applies generalised per-operand forwarding from every lane's M and W results.
- Runs one ALU per lane.
- Adds an iterative shift-add multiplier on lane 0 that stalls the pipe, plus an all-pairs intra-bundle RAW/WAW dependency vector with $0 exclusion.

Parameters:
- LANES, 2, issue width (1..4).
- DATA_W, 32, datapath width.
- FSEL_W, $clog2(2*LANES+1), width of one forward-select field.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- flushE  in  1  bubble all lanes into E
- stallE  in  1  hold E register
- validD  in  LANES  lane carries an instruction
- RegWriteD, MemWriteD, regdstD, jumpD, mulD  in  LANES each  per-lane controls; mulD is honoured on lane 0 only
- MemtoRegD  in  4*LANES  packed
- alucontrolD  in  3*LANES  packed
- alusrcD  in  2*LANES  packed; 00 reg, 01 signimm, 1x unsignimm
- RD1D, RD2D, signimmD, unsignimmD  in  DATA_W*LANES each  packed
- RsD, RtD, RdD  in  5*LANES each  packed
- PCPlus4D  in  DATA_W  bundle PC+4
- fwdA, fwdB  in  FSEL_W*LANES each  0 = register value; k in 1..LANES = aluoutM lane k-1; LANES+1..2*LANES = resultW lane k-LANES-1
- aluoutM, resultW  in  DATA_W*LANES each
- depD  out  LANES  bit j: lane j conflicts with some lane i<j
- stall_req  out  1  multiplier busy
- validE, RegWriteE, MemWriteE, jumpE  out  LANES each
- MemtoRegE  out  4*LANES
- RsE, RtE, writeregE  out  5*LANES each
- aluoutE, writedataE  out  DATA_W*LANES each
- PCPlus4E  out  DATA_W

Behaviour:
- Register priority:
  - rst: all E fields 0, async.
  - Multiplier in RUN: hold, with flushE and stallE ignored.
  - flushE: all fields 0, so validE=0 and no writes.
  - stallE: hold.
  - Otherwise capture D.
- Stored register indices are 5 bits wide, not 32.
- srcA/srcB come from the fwdA/fwdB mux. Select values above 2*LANES return the register value.
- writedataE = forwarded srcB before the immediate mux.
- The operand-B immediate is chosen by alusrc.
- writeregE = regdst ? Rd : Rt.
- aluoutE is combinational from the E register and forwarding inputs, with zero added latency.
- depD (combinational on D inputs): bit j = OR over i<j of (validD[i] && validD[j] && RegWriteD[i] && wr_i!=0) && (RsD[j]==wr_i || RtD[j]==wr_i || (RegWriteD[j] && wr_j==wr_i)). Here wr = regdst ? Rd : Rt. depD[0] is always 0.
- Multiplier FSM, states IDLE, RUN, DONE:
  - IDLE: if validE[0] && mul flag captured and state IDLE, on the first E cycle latch srcA0 and srcB0 as forwarded that cycle, clear product and count, go to RUN. Forwarded values are valid only on that cycle.
  - RUN: each cycle, if multiplier bit0 then product += multiplicand; multiplicand <<= 1; multiplier >>= 1; count++. Leave RUN after DATA_W cycles and go to DONE.
  - stall_req = (state==RUN), including the capture cycle. This gives DATA_W+1 total E cycles for a mul.
  - DONE: aluoutE lane0 = product[DATA_W-1:0] (low word, unsigned = signed low word). Return to IDLE on the next cycle where the register advances.
  - Lanes ≥1 keep their E contents and outputs stable during RUN.
  - rst mid-RUN returns to IDLE with stall_req=0 immediately.
- All outputs are 0 on reset, including stall_req and depD for all-zero inputs.

Decomposition:
- Shared pkg holds the ALU control encodings, the alusrc encodings, and the forward-select encoding constants (FWD_REG=0, M base 1, W base LANES+1).
- The existing ALU module is instantiated per lane via a generate block.
- One sub-module, iter_mul (FSM + shift-add datapath, ports start/a/b/busy/done/p), is natural.

Test Plan:
- LANES=2, reset:
  - Stimulus: rst pulse mid-cycle.
  - Response: all E outputs 0, stall_req=0, validE=00.
- Forwarding:
  - Stimulus: RD1D lane1=5, fwdA lane1=1 (aluoutM lane0=0x10), add.
  - Response: aluoutE lane1 = 0x10+srcB.
  - Stimulus: fwdA lane1=4.
  - Response: uses resultW lane1.
- Dependency:
  - Stimulus: lane0 add $3 with RegWrite, lane1 Rs=$3.
  - Response: depD=10.
  - Stimulus: same with dest $0.
  - Response: depD=00.
  - Stimulus: lane1 writes $3 too with Rs≠$3.
  - Response: depD=10 (WAW).
- Multiply:
  - Stimulus: lane0 mul, srcA=7, srcB=0xFFFFFFFF.
  - Response: stall_req high 33 cycles with the E register frozen despite stallE=0, then aluoutE0=0xFFFFFFF9.
  - Stimulus: same with srcA=0.
  - Response: result 0.
- Flush and stall:
  - Stimulus: flushE with valid inputs.
  - Response: next cycle validE=00, RegWriteE=00.
  - Stimulus: stallE held 3 cycles.
  - Response: outputs unchanged.
  - Stimulus: flushE during mul RUN.
  - Response: ignored.
- Reset mid-mul:
  - Stimulus: rst at RUN cycle 10.
  - Response: stall_req drops asynchronously; the next mul computes correctly from IDLE.

Source files
------------

// File: rtl/execute_nway_pkg.sv
// execute_nway_pkg: shared ALU, operand-source and forward-select encodings plus multiplier states
package execute_nway_pkg;
  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_XOR  = 3'b011;
  localparam logic [2:0] ALU_NOR  = 3'b100;
  localparam logic [2:0] ALU_SLTU = 3'b101;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;
  localparam logic [1:0] SRC_REG  = 2'b00;
  localparam logic [1:0] SRC_SIMM = 2'b01;
  localparam int SRC_UIMM_BIT = 1;
  localparam int FWD_REG    = 0;
  localparam int FWD_M_BASE = FWD_REG + 1;
  function automatic int fwd_w_base(input int lanes);
    return FWD_M_BASE + lanes;
  endfunction
  typedef enum logic [1:0] {MUL_IDLE, MUL_RUN, MUL_DONE} mul_state_e;
endpackage

// File: rtl/execute_nway_alu.sv
// alu: single-lane combinational ALU
module alu
  import execute_nway_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [2:0]   ctl,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  assign y = ctl == ALU_AND ? a & b :
             ctl == ALU_OR  ? a | b :
             ctl == ALU_ADD ? a + b :
             ctl == ALU_XOR ? a ^ b :
             ctl == ALU_NOR ? ~(a | b) :
             ctl == ALU_SUB ? a - b :
             ctl == ALU_SLT ? W'($signed(a) < $signed(b)) :
             ctl == ALU_SLTU ? W'(a < b) : '0;
endmodule

// File: rtl/execute_nway_iter_mul.sv
// iter_mul: shift-add multiplier, one multiplier bit per cycle, low word result
module iter_mul
  import execute_nway_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              adv,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] p
);
  localparam int CW = $clog2(DATA_W) + 1;
  mul_state_e state_q, state_d;
  logic [DATA_W-1:0] mcand_q, mcand_d, mplier_q, mplier_d, p_q, p_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // state and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= MUL_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      p_q      <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      p_q      <= p_d;
      cnt_q    <= cnt_d;
    end
  end
  // operands are sampled on the start cycle only; DONE holds until the E register moves on
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    p_d      = p_q;
    cnt_d    = cnt_q;
    case (state_q)
      MUL_IDLE: if (start) begin
        mcand_d  = a;
        mplier_d = b;
        p_d      = '0;
        cnt_d    = '0;
        state_d  = MUL_RUN;
      end
      MUL_RUN: begin
        p_d      = mplier_q[0] ? p_q + mcand_q : p_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        state_d  = cnt_q == CW'(DATA_W - 1) ? MUL_DONE : MUL_RUN;
      end
      MUL_DONE: state_d = adv ? MUL_IDLE : MUL_DONE;
      default: state_d = MUL_IDLE;
    endcase
  end
  assign busy = state_q == MUL_RUN || (state_q == MUL_IDLE && start);
  assign done = state_q == MUL_DONE;
  assign p    = p_q;
endmodule

// File: rtl/execute_nway.sv
// execute_nway: N-lane ID/EX register, per-operand forwarding, per-lane ALUs, lane-0 multiplier, bundle hazards
module execute_nway
  import execute_nway_pkg::*;
#(
  parameter int LANES  = 2,
  parameter int DATA_W = 32,
  parameter int FSEL_W = $clog2(2*LANES+1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flushE,
  input  logic                     stallE,
  input  logic [LANES-1:0]         validD,
  input  logic [LANES-1:0]         RegWriteD,
  input  logic [LANES-1:0]         MemWriteD,
  input  logic [LANES-1:0]         regdstD,
  input  logic [LANES-1:0]         jumpD,
  input  logic [LANES-1:0]         mulD,
  input  logic [4*LANES-1:0]       MemtoRegD,
  input  logic [3*LANES-1:0]       alucontrolD,
  input  logic [2*LANES-1:0]       alusrcD,
  input  logic [DATA_W*LANES-1:0]  RD1D,
  input  logic [DATA_W*LANES-1:0]  RD2D,
  input  logic [DATA_W*LANES-1:0]  signimmD,
  input  logic [DATA_W*LANES-1:0]  unsignimmD,
  input  logic [5*LANES-1:0]       RsD,
  input  logic [5*LANES-1:0]       RtD,
  input  logic [5*LANES-1:0]       RdD,
  input  logic [DATA_W-1:0]        PCPlus4D,
  input  logic [FSEL_W*LANES-1:0]  fwdA,
  input  logic [FSEL_W*LANES-1:0]  fwdB,
  input  logic [DATA_W*LANES-1:0]  aluoutM,
  input  logic [DATA_W*LANES-1:0]  resultW,
  output logic [LANES-1:0]         depD,
  output logic                     stall_req,
  output logic [LANES-1:0]         validE,
  output logic [LANES-1:0]         RegWriteE,
  output logic [LANES-1:0]         MemWriteE,
  output logic [LANES-1:0]         jumpE,
  output logic [4*LANES-1:0]       MemtoRegE,
  output logic [5*LANES-1:0]       RsE,
  output logic [5*LANES-1:0]       RtE,
  output logic [5*LANES-1:0]       writeregE,
  output logic [DATA_W*LANES-1:0]  aluoutE,
  output logic [DATA_W*LANES-1:0]  writedataE,
  output logic [DATA_W-1:0]        PCPlus4E
);
  localparam int EW = LANES*(28 + 4*DATA_W) + 1 + DATA_W;
  logic [EW-1:0] d_bus, e_d, e_q;
  logic [5*LANES-1:0] wr_d;
  logic [3*LANES-1:0] alu_ctl_e;
  logic [2*LANES-1:0] alusrc_e;
  logic [DATA_W*LANES-1:0] rd1_e, rd2_e, simm_e, uimm_e;
  logic [DATA_W-1:0] src_a0, src_b0, mul_p;
  logic mul_e, mul_done;
  assign d_bus = {PCPlus4D, |(mulD & LANES'(1)), validD, RegWriteD, MemWriteD, jumpD, MemtoRegD,
                  alucontrolD, alusrcD, RD1D, RD2D, signimmD, unsignimmD, RsD, RtD, wr_d};
  assign {PCPlus4E, mul_e, validE, RegWriteE, MemWriteE, jumpE, MemtoRegE,
          alu_ctl_e, alusrc_e, rd1_e, rd2_e, simm_e, uimm_e, RsE, RtE, writeregE} = e_q;
  // ID/EX register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) e_q <= '0;
    else e_q <= e_d;
  end
  // a running multiply freezes E over flush and stall; flush beats stall
  always_comb e_d = stall_req ? e_q : flushE ? '0 : stallE ? e_q : d_bus;
  // a later lane reading or rewriting an earlier lane's non-$0 destination
  always_comb begin
    depD = '0;
    for (int j = 1; j < LANES; j++)
      for (int i = 0; i < j; i++)
        if (validD[i] && validD[j] && RegWriteD[i] && wr_d[5*i +: 5] != 5'd0 &&
            (RsD[5*j +: 5] == wr_d[5*i +: 5] || RtD[5*j +: 5] == wr_d[5*i +: 5] ||
             (RegWriteD[j] && wr_d[5*j +: 5] == wr_d[5*i +: 5])))
          depD[j] = 1'b1;
  end
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [DATA_W-1:0] sa, sb, y;
    logic [FSEL_W-1:0] fa, fb;
    logic [1:0] src;
    assign fa  = fwdA[FSEL_W*i +: FSEL_W];
    assign fb  = fwdB[FSEL_W*i +: FSEL_W];
    assign src = alusrc_e[2*i +: 2];
    assign wr_d[5*i +: 5] = regdstD[i] ? RdD[5*i +: 5] : RtD[5*i +: 5];
    // operand forwarding; unmatched selects fall back to the register value
    always_comb begin
      sa = rd1_e[DATA_W*i +: DATA_W];
      sb = rd2_e[DATA_W*i +: DATA_W];
      for (int k = 0; k < LANES; k++) begin
        if (int'(fa) == FWD_M_BASE + k) sa = aluoutM[DATA_W*k +: DATA_W];
        if (int'(fa) == fwd_w_base(LANES) + k) sa = resultW[DATA_W*k +: DATA_W];
        if (int'(fb) == FWD_M_BASE + k) sb = aluoutM[DATA_W*k +: DATA_W];
        if (int'(fb) == fwd_w_base(LANES) + k) sb = resultW[DATA_W*k +: DATA_W];
      end
    end
    alu #(.W(DATA_W)) u_alu (
      .ctl(alu_ctl_e[3*i +: 3]),
      .a(sa),
      .b(src[SRC_UIMM_BIT] ? uimm_e[DATA_W*i +: DATA_W] : src == SRC_REG ? sb : simm_e[DATA_W*i +: DATA_W]),
      .y(y)
    );
    assign writedataE[DATA_W*i +: DATA_W] = sb;
    assign aluoutE[DATA_W*i +: DATA_W]    = (i == 0 && mul_done) ? mul_p : y;
    if (i == 0) begin : g_l0
      assign src_a0 = sa;
      assign src_b0 = sb;
    end
  end
  iter_mul #(.DATA_W(DATA_W)) u_mul (
    .clk(clk),
    .rst(rst),
    .start(validE[0] & mul_e),
    .adv(flushE | ~stallE),
    .a(src_a0),
    .b(src_b0),
    .busy(stall_req),
    .done(mul_done),
    .p(mul_p)
  );
endmodule

// File: tb/tb_execute_nway.sv
// tb_execute_nway: directed checks of execute_nway with two lanes
module tb_execute_nway;
  localparam int L = 2, W = 32, F = 3;
  localparam logic [2:0] ADD = 3'b010;
  logic clk = 1'b0, rst = 1'b0, flushE, stallE;
  logic [L-1:0] validD, RegWriteD, MemWriteD, regdstD, jumpD, mulD;
  logic [4*L-1:0] MemtoRegD;
  logic [3*L-1:0] alucontrolD;
  logic [2*L-1:0] alusrcD;
  logic [W*L-1:0] RD1D, RD2D, signimmD, unsignimmD, aluoutM, resultW;
  logic [5*L-1:0] RsD, RtD, RdD;
  logic [W-1:0] PCPlus4D;
  logic [F*L-1:0] fwdA, fwdB;
  logic [L-1:0] depD, validE, RegWriteE, MemWriteE, jumpE;
  logic stall_req;
  logic [4*L-1:0] MemtoRegE;
  logic [5*L-1:0] RsE, RtE, writeregE;
  logic [W*L-1:0] aluoutE, writedataE;
  logic [W-1:0] PCPlus4E;
  int checks = 0, errors = 0, n;

  execute_nway #(.LANES(L), .DATA_W(W)) dut (
    .clk(clk), .rst(rst), .flushE(flushE), .stallE(stallE), .validD(validD),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .regdstD(regdstD), .jumpD(jumpD), .mulD(mulD),
    .MemtoRegD(MemtoRegD), .alucontrolD(alucontrolD), .alusrcD(alusrcD), .RD1D(RD1D), .RD2D(RD2D),
    .signimmD(signimmD), .unsignimmD(unsignimmD), .RsD(RsD), .RtD(RtD), .RdD(RdD),
    .PCPlus4D(PCPlus4D), .fwdA(fwdA), .fwdB(fwdB), .aluoutM(aluoutM), .resultW(resultW),
    .depD(depD), .stall_req(stall_req), .validE(validE), .RegWriteE(RegWriteE),
    .MemWriteE(MemWriteE), .jumpE(jumpE), .MemtoRegE(MemtoRegE), .RsE(RsE), .RtE(RtE),
    .writeregE(writeregE), .aluoutE(aluoutE), .writedataE(writedataE), .PCPlus4E(PCPlus4E)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clr;
    validD = '0; RegWriteD = '0; MemWriteD = '0; regdstD = '0; jumpD = '0; mulD = '0;
    MemtoRegD = '0; alucontrolD = '0; alusrcD = '0; RD1D = '0; RD2D = '0;
    signimmD = '0; unsignimmD = '0; RsD = '0; RtD = '0; RdD = '0; PCPlus4D = '0;
    fwdA = '0; fwdB = '0; aluoutM = '0; resultW = '0;
  endtask

  task automatic run_mul(input int flush_at, output int cnt);
    cnt = 0;
    while (stall_req && cnt < 100) begin
      flushE = (cnt == flush_at);
      step();
      cnt++;
    end
    flushE = 1'b0;
  endtask

  initial begin
    clr();
    flushE = 1'b0;
    stallE = 1'b0;
    #3 rst = 1'b1;
    #1;
    chk("rst_valid", 32'(validE), 32'h0);
    chk("rst_stall", 32'(stall_req), 32'h0);
    chk("rst_alu0", aluoutE[31:0], 32'h0);
    chk("rst_pc", PCPlus4E, 32'h0);
    chk("rst_dep", 32'(depD), 32'h0);
    @(negedge clk) rst = 1'b0;
    step();
    chk("post_rst_valid", 32'(validE), 32'h0);
    // forwarding on lane 1
    validD = 2'b11; alucontrolD = {ADD, ADD};
    RD1D[63:32] = 32'd5; RD2D[63:32] = 32'd3;
    aluoutM = {32'h20, 32'h10}; resultW[63:32] = 32'h100;
    fwdA[5:3] = 3'd1;
    step();
    chk("fwd_m", aluoutE[63:32], 32'h13);
    chk("fwd_wd", writedataE[63:32], 32'd3);
    fwdA[5:3] = 3'd4; #1;
    chk("fwd_w", aluoutE[63:32], 32'h103);
    fwdA[5:3] = 3'd7; #1;
    chk("fwd_oob", aluoutE[63:32], 32'h8);
    fwdA[5:3] = 3'd0; fwdB[5:3] = 3'd2; #1;
    chk("fwd_b", aluoutE[63:32], 32'h25);
    chk("fwd_b_wd", writedataE[63:32], 32'h20);
    // immediates and destination select
    clr();
    validD = 2'b11; alucontrolD = {ADD, ADD}; alusrcD = {2'b10, 2'b01};
    RD1D = {32'd2, 32'd10}; RD2D = {32'd77, 32'd66};
    signimmD[31:0] = 32'hFFFF_FFFE; unsignimmD[63:32] = 32'h0000_FFFE;
    regdstD = 2'b01; RdD = {5'd0, 5'd7}; RtD = {5'd9, 5'd4};
    step();
    chk("imm_s", aluoutE[31:0], 32'd8);
    chk("imm_u", aluoutE[63:32], 32'h0001_0000);
    chk("imm_wd", writedataE[31:0], 32'd66);
    chk("wreg", 32'(writeregE), 32'h127);
    // bundle dependencies
    clr();
    validD = 2'b11; RegWriteD = 2'b01; regdstD = 2'b01; RdD[4:0] = 5'd3;
    RsD[9:5] = 5'd3; RtD[9:5] = 5'd5; #1;
    chk("dep_raw", 32'(depD), 32'h2);
    RdD[4:0] = 5'd0; #1;
    chk("dep_zero", 32'(depD), 32'h0);
    RdD[4:0] = 5'd3; RsD[9:5] = 5'd4; RegWriteD = 2'b11; regdstD = 2'b11; RdD[9:5] = 5'd3; #1;
    chk("dep_waw", 32'(depD), 32'h2);
    validD = 2'b01; #1;
    chk("dep_inv", 32'(depD), 32'h0);
    // flush
    validD = 2'b11; RegWriteD = 2'b11; flushE = 1'b1;
    step();
    chk("flush_v", 32'(validE), 32'h0);
    chk("flush_rw", 32'(RegWriteE), 32'h0);
    flushE = 1'b0;
    // stall
    clr();
    validD = 2'b11; alucontrolD = {ADD, ADD}; RD1D = {32'd4, 32'd1}; RD2D = {32'd5, 32'd1};
    PCPlus4D = 32'h44;
    step();
    chk("st_pre", aluoutE[63:32], 32'd9);
    stallE = 1'b1; validD = '0; PCPlus4D = 32'h88; RD1D = '0;
    repeat (3) step();
    chk("st_v", 32'(validE), 32'h3);
    chk("st_pc", PCPlus4E, 32'h44);
    chk("st_alu", aluoutE[63:32], 32'd9);
    stallE = 1'b0;
    // multiply 7 * 0xFFFFFFFF with a flush attempted mid-run
    clr();
    validD = 2'b11; mulD = 2'b01; alucontrolD = {ADD, ADD};
    RD1D = {32'd1, 32'd7}; RD2D = {32'd2, 32'hFFFF_FFFF}; PCPlus4D = 32'h100;
    step();
    chk("mul_start", 32'(stall_req), 32'h1);
    clr();
    PCPlus4D = 32'h200;
    run_mul(5, n);
    chk("mul_cyc", n, 32'd33);
    chk("mul_p", aluoutE[31:0], 32'hFFFF_FFF9);
    chk("mul_hold_v", 32'(validE), 32'h3);
    chk("mul_hold_pc", PCPlus4E, 32'h100);
    chk("mul_l1", aluoutE[63:32], 32'd3);
    step();
    chk("mul_adv", PCPlus4E, 32'h200);
    chk("mul_idle", 32'(stall_req), 32'h0);
    // multiply by a forwarded zero, forward source changes after the start cycle
    clr();
    validD = 2'b01; mulD = 2'b01; RD1D[31:0] = 32'd9; RD2D[31:0] = 32'hFFFF_FFFF;
    fwdA[2:0] = 3'd1;
    step();
    chk("mul0_start", 32'(stall_req), 32'h1);
    validD = '0;
    step();
    aluoutM[31:0] = 32'h55;
    run_mul(-1, n);
    chk("mul0_cyc", n, 32'd32);
    chk("mul0_p", aluoutE[31:0], 32'h0);
    step();
    // reset during a run, then a clean multiply
    clr();
    validD = 2'b01; mulD = 2'b01; RD1D[31:0] = 32'd3; RD2D[31:0] = 32'd5;
    step();
    repeat (10) step();
    chk("rm_busy", 32'(stall_req), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("rm_drop", 32'(stall_req), 32'h0);
    chk("rm_v", 32'(validE), 32'h0);
    #1 rst = 1'b0;
    clr();
    validD = 2'b01; mulD = 2'b01; RD1D[31:0] = 32'd6; RD2D[31:0] = 32'd7;
    step();
    clr();
    run_mul(-1, n);
    chk("rm_cyc", n, 32'd33);
    chk("rm_p", aluoutE[31:0], 32'd42);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
